// File: rtl/data_sram_slave.sv
// Data SRAM responder: byte-lane word store, one-entry posted-write buffer with read bypass, post-reset clear.
// Optional access checking is built only when DATA_SRAM_ERRCHK_EN is defined.
module data_sram_slave #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        init_done,
    output logic        data_sram_err
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              init_done_reg;

    logic              wbuf_valid_reg;
    logic [ADDR_W-1:0] wbuf_idx_reg;
    logic [3:0]        wbuf_wen_reg;
    logic [31:0]       wbuf_data_reg;

    logic              rvalid_reg;
    logic              hit_reg;
    logic [3:0]        hit_mask_reg;
    logic [31:0]       hit_data_reg;
    logic [31:0]       rdata_hold_reg;

    logic [ADDR_W-1:0] req_idx;
    logic              is_run;
    logic              rd_req;
    logic              wr_req;
    logic              commit;

    logic [ADDR_W-1:0] port_addr;
    logic [3:0]        port_we;
    logic [31:0]       port_wdata;
    logic [31:0]       mem_word;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    assign req_idx = data_sram_addr[ADDR_W+1:2];
    assign is_run  = (state_reg == RUN);
    assign rd_req  = is_run && data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_req  = is_run && data_sram_en && (data_sram_wen != 4'b0000);
    // The pending write may use the port whenever no read claims it.
    assign commit  = is_run && wbuf_valid_reg && !rd_req;

    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    always_comb begin
        port_addr  = req_idx;
        port_we    = 4'b0000;
        port_wdata = wbuf_data_reg;
        if (!reset) begin
            if (state_reg == CLEAR) begin
                port_addr  = cnt_reg;
                port_we    = 4'b1111;
                port_wdata = INIT_VAL;
            end else if (commit) begin
                port_addr  = wbuf_idx_reg;
                port_we    = wbuf_wen_reg;
            end
        end
    end

    // One block-RAM lane per byte; read data overlaid with the buffered bytes on a hit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [1 << ADDR_W];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (port_we[gi]) begin
                    lane_mem[port_addr] <= port_wdata[8*gi +: 8];
                end
                lane_q_reg <= lane_mem[port_addr];
            end

            assign mem_word[8*gi +: 8] = lane_q_reg;
            assign rd_word[8*gi +: 8]  = (hit_reg && hit_mask_reg[gi]) ?
                                         hit_data_reg[8*gi +: 8] : lane_q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= CLEAR;
            cnt_reg        <= '0;
            init_done_reg  <= 1'b0;
            wbuf_valid_reg <= 1'b0;
            wbuf_idx_reg   <= '0;
            wbuf_wen_reg   <= 4'b0000;
            wbuf_data_reg  <= 32'h0;
            rvalid_reg     <= 1'b0;
            hit_reg        <= 1'b0;
            hit_mask_reg   <= 4'b0000;
            hit_data_reg   <= 32'h0;
            rdata_hold_reg <= 32'h0;
        end else begin
            rvalid_reg   <= rd_req;
            hit_reg      <= wbuf_valid_reg && (wbuf_idx_reg == req_idx);
            hit_mask_reg <= wbuf_wen_reg;
            hit_data_reg <= wbuf_data_reg;
            if (rvalid_reg) begin
                rdata_hold_reg <= rd_word;
            end

            case (state_reg)
                CLEAR: begin
                    cnt_reg <= cnt_reg + ADDR_W'(1);
                    if (&cnt_reg) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_req) begin
                        wbuf_valid_reg <= 1'b1;
                        wbuf_idx_reg   <= req_idx;
                        wbuf_wen_reg   <= data_sram_wen;
                        wbuf_data_reg  <= data_sram_wdata;
                    end else if (commit) begin
                        wbuf_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    assign data_sram_rvalid = rvalid_reg;
    assign data_sram_rdata  = rvalid_reg ? rd_word : rdata_hold_reg;
    assign init_done        = init_done_reg;

`ifdef DATA_SRAM_ERRCHK_EN
    logic err_reg;
    logic err_next;
    logic hi_bad;
    logic wen_bad;

    assign hi_bad = |data_sram_addr[31:ADDR_W+2];

    always_comb begin
        wen_bad = 1'b0;
        case (data_sram_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_bad = 1'b0;
            4'b0011, 4'b1100: wen_bad = data_sram_addr[0];
            4'b1111:          wen_bad = |data_sram_addr[1:0];
            default:          wen_bad = 1'b1;
        endcase
    end

    assign err_next = is_run && data_sram_en && (hi_bad || wen_bad);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign data_sram_err = err_reg;
`else
    assign data_sram_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: clear latency, read latency, bypass, merge, wrap, mid-op reset, error pulses.
module tb_data_sram_slave;

`ifdef DATA_SRAM_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        init_done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    data_sram_slave #(.ADDR_W(10), .INIT_VAL(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .data_sram_rvalid(rvalid),
        .init_done       (init_done),
        .data_sram_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 36;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] d, input logic rv, input logic [31:0] rd,
                                input logic er);
        vec_t v;
        v.en = e; v.wen = w; v.addr = a; v.wdata = d;
        v.exp_rvalid = rv; v.exp_rdata = rd; v.exp_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Vector i drives cycle i; its read/err result is sampled right after that cycle's edge.
        vecs[0]  = mk(1, 4'b0000, 32'h0000_0FFC, 32'h0,          1, 32'h0000_0000, 0);
        vecs[1]  = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h0000_0000, 0);
        vecs[2]  = mk(1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF,  0, 32'h0000_0000, 0);
        vecs[3]  = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h0000_0000, 0);
        vecs[4]  = mk(1, 4'b0000, 32'h0000_0010, 32'h0,          1, 32'hDEAD_BEEF, 0);
        vecs[5]  = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'hDEAD_BEEF, 0);
        vecs[6]  = mk(1, 4'b1111, 32'h0000_0020, 32'h1122_3344,  0, 32'hDEAD_BEEF, 0);
        vecs[7]  = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'hDEAD_BEEF, 0);
        vecs[8]  = mk(1, 4'b0010, 32'h0000_0020, 32'h0000_AB00,  0, 32'hDEAD_BEEF, 0);
        vecs[9]  = mk(1, 4'b0000, 32'h0000_0020, 32'h0,          1, 32'h1122_AB44, 0);
        vecs[10] = mk(1, 4'b0000, 32'h0000_0020, 32'h0,          1, 32'h1122_AB44, 0);
        vecs[11] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h1122_AB44, 0);
        vecs[12] = mk(1, 4'b0000, 32'h0000_0020, 32'h0,          1, 32'h1122_AB44, 0);
        vecs[13] = mk(1, 4'b0001, 32'h0000_0040, 32'h0000_00AA,  0, 32'h1122_AB44, 0);
        vecs[14] = mk(1, 4'b1000, 32'h0000_0040, 32'hBB00_0000,  0, 32'h1122_AB44, 0);
        vecs[15] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h1122_AB44, 0);
        vecs[16] = mk(1, 4'b0000, 32'h0000_0040, 32'h0,          1, 32'hBB00_00AA, 0);
        vecs[17] = mk(1, 4'b1111, 32'h0000_1004, 32'h5A5A_5A5A,  0, 32'hBB00_00AA, 1);
        vecs[18] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'hBB00_00AA, 0);
        vecs[19] = mk(1, 4'b0000, 32'h0000_0004, 32'h0,          1, 32'h5A5A_5A5A, 0);
        vecs[20] = mk(1, 4'b1111, 32'h0000_0044, 32'h0102_0304,  0, 32'h5A5A_5A5A, 0);
        vecs[21] = mk(1, 4'b0000, 32'h0000_0048, 32'h0,          1, 32'h0000_0000, 0);
        vecs[22] = mk(1, 4'b0000, 32'h0000_0044, 32'h0,          1, 32'h0102_0304, 0);
        vecs[23] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h0102_0304, 0);
        vecs[24] = mk(1, 4'b0000, 32'h0001_0000, 32'h0,          1, 32'h0000_0000, 1);
        vecs[25] = mk(1, 4'b0110, 32'h0000_0050, 32'h00FF_FF00,  0, 32'h0000_0000, 1);
        vecs[26] = mk(1, 4'b1100, 32'h0000_0052, 32'hCAFE_0000,  0, 32'h0000_0000, 0);
        vecs[27] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h0000_0000, 0);
        vecs[28] = mk(1, 4'b0000, 32'h0000_0050, 32'h0,          1, 32'hCAFE_FF00, 0);
        vecs[29] = mk(1, 4'b0000, 32'h0000_0051, 32'h0,          1, 32'hCAFE_FF00, 0);
        vecs[30] = mk(1, 4'b1111, 32'h0000_0056, 32'h7777_7777,  0, 32'hCAFE_FF00, 1);
        vecs[31] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'hCAFE_FF00, 0);
        vecs[32] = mk(1, 4'b0000, 32'h0000_0054, 32'h0,          1, 32'h7777_7777, 0);
        vecs[33] = mk(1, 4'b0011, 32'h0000_0059, 32'h0000_BEEF,  0, 32'h7777_7777, 1);
        vecs[34] = mk(1, 4'b0000, 32'h0000_0058, 32'h0,          1, 32'h0000_BEEF, 0);
        vecs[35] = mk(0, 4'b0000, 32'h0,         32'h0,          0, 32'h0000_BEEF, 0);

        reset = 1'b1; en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset rvalid", {31'h0, rvalid}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        check("reset init_done", {31'h0, init_done}, 32'h0);
        check("reset err", {31'h0, err}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 1023; i++) begin
            @(posedge clk); #1;
        end
        check("init_done after 1023 cycles", {31'h0, init_done}, 32'h0);
        @(posedge clk); #1;
        check("init_done after 1024 cycles", {31'h0, init_done}, 32'h1);
        $display("clear complete init_done=%0b", init_done);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            $display("vec %0d en=%0b wen=%04b addr=%08h wdata=%08h -> rvalid=%0b rdata=%08h err=%0b",
                     i, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, rvalid, rdata, err);
            check($sformatf("v%0d rvalid", i), {31'h0, rvalid}, {31'h0, vecs[i].exp_rvalid});
            check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), {31'h0, err}, {31'h0, ERRCHK & vecs[i].exp_err});
        end

        // Reset right after a posted write: the write must be dropped and the clear restarted.
        drive(1'b1, 4'b1111, 32'h0000_0030, 32'h1234_5678);
        $display("mid-op write addr=00000030 wdata=12345678");
        reset = 1'b1;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("midreset rvalid", {31'h0, rvalid}, 32'h0);
        check("midreset rdata", rdata, 32'h0);
        check("midreset init_done", {31'h0, init_done}, 32'h0);
        check("midreset err", {31'h0, err}, 32'h0);
        reset = 1'b0;

        n = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0000, 32'h0000_0030, 32'h0);
            n++;
            check($sformatf("clear read %0d rvalid", i), {31'h0, rvalid}, 32'h0);
        end
        drive(1'b1, 4'b1111, 32'h0000_0030, 32'hFFFF_FFFF);
        n++;
        check("clear write init_done", {31'h0, init_done}, 32'h0);
        en = 1'b0; wen = 4'b0000;
        while (!init_done && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        check("second clear latency", n, 32'd1024);
        $display("second clear done after %0d cycles", n);

        drive(1'b1, 4'b0000, 32'h0000_0030, 32'h0);
        $display("read addr=00000030 -> rvalid=%0b rdata=%08h", rvalid, rdata);
        check("post-reset 0x30 rvalid", {31'h0, rvalid}, 32'h1);
        check("post-reset 0x30 rdata", rdata, 32'h0);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("post-reset rvalid low", {31'h0, rvalid}, 32'h0);
        drive(1'b1, 4'b0000, 32'h0000_0010, 32'h0);
        $display("read addr=00000010 -> rvalid=%0b rdata=%08h", rvalid, rdata);
        check("post-reset 0x10 rdata", rdata, 32'h0);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_sram_slave.md
Name: data_sram_slave

Overview:
- Responder end of the data SRAM interface that the execute stage drives (en / wen / addr / wdata).
- Provides single-port synchronous word storage with byte-lane writes and one-cycle read latency.
- A one-entry posted-write buffer with read bypass keeps the single array port free for reads.
- After reset, a clear FSM initialises every word; `init_done` gates the CPU until the clear finishes.

Parameters:
- ADDR_W, 10, word-index width; depth = 2^ADDR_W words.
- INIT_VAL, 32'h0000_0000, value written to every word during the clear.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- data_sram_en  input  1  access request this cycle
- data_sram_wen  input  4  byte write enables; 0 means read
- data_sram_addr  input  32  byte address; word index = addr[ADDR_W+1:2]
- data_sram_wdata  input  32  write data, lane-replicated by initiator
- data_sram_rdata  output  32  read data
- data_sram_rvalid  output  1  one-cycle pulse: rdata valid
- init_done  output  1  1 once clear complete; initiator must not issue en while 0
- data_sram_err  output  1  access-error pulse (optional feature; tied 0 when absent)

Behaviour:
- Single clock `clk`; `reset` is synchronous and active-high.
- Reset values: rdata=0, rvalid=0, init_done=0, err=0, wbuf_valid=0, clear counter=0, state=CLEAR.
- Reset asserted mid-operation discards any pending wbuf write and any in-flight read, then restarts the clear.

State CLEAR:
- Writes INIT_VAL to word `cnt` each cycle, cnt 0 to DEPTH-1.
- All requests are ignored: no write captured, rvalid stays 0.
- After writing word DEPTH-1, go to RUN and set init_done=1. Clear latency = DEPTH cycles after reset deasserts.

State RUN, read (en=1, wen=0) in cycle T:
- The array port reads the index.
- In T+1: rvalid=1 and rdata = array word, with wbuf bytes overlaid on enabled lanes if wbuf_valid and wbuf index equals the read index.
- The overlay uses the wbuf state at T (hit, mask and data are registered at T).
- rdata holds its value when rvalid=0.

State RUN, write (en=1, wen≠0) in cycle T:
- If wbuf_valid, the old wbuf commits to the array in T (the port is free).
- The new {index, wen, wdata} is captured into wbuf; wbuf_valid=1.
- No rvalid for writes.

State RUN, idle or read cycles:
- Idle (en=0): a pending wbuf commits and wbuf_valid becomes 0.
- Read cycle: wbuf stays pending (port busy) and the bypass covers it.
- Back-to-back reads therefore never lose the posted write.

Width and address rules:
- Byte lane k = wdata[8k+7:8k] is written iff wen[k].
- Address bits above ADDR_W+1 and addr[1:0] are ignored; the index wraps modulo DEPTH.
- Consecutive writes to the same index: the second merges correctly because the first commits in the same cycle the second is captured.

Optional Feature:
- Macro: DATA_SRAM_ERRCHK_EN.
- With the macro, data_sram_err=1 for one cycle at T+1 when an en=1 request at T (RUN only) has either:
  - addr[31:ADDR_W+2] ≠ 0, or
  - wen not in {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111}, or
  - a halfword wen with addr[0]=1, or wen=1111 with addr[1:0]≠0.
- The access is still performed on the truncated index and given wen.
- Without the macro, data_sram_err is constant 0 and no check logic is built.

Test Plan:
- Clear: reset 1 cycle, then hold en=0 → init_done rises exactly 1024 cycles later; read addr 0x0000_0FFC → rdata=0x0000_0000, rvalid one pulse at T+1.
- Read latency: write wen=1111 addr 0x10 data 0xDEADBEEF, idle, read 0x10 at T → rvalid=1 and rdata=0xDEADBEEF at T+1, rvalid=0 at T+2.
- Bypass: write wen=0010 addr 0x20 data 0x0000AB00 (word 0x11223344), then read 0x20 the next cycle → rdata=0x1122AB44 with the write still pending.
- Merge and wrap: write wen=0001 data 0x000000AA then wen=1000 data 0xBB000000 to addr 0x40, back-to-back, idle, read → 0xBB0000AA; write 0x1004 data 0x5A5A5A5A, read 0x0004 → 0x5A5A5A5A.
- Reset mid-op: write 0x30 data 0x12345678, assert reset the next cycle before any idle → after clear, read 0x30 → 0x00000000; rvalid/rdata/init_done are 0 during reset.
- ERRCHK (macro on): read addr 0x0001_0000 → err=1 at T+1 with rvalid=1; write wen=0110 → err=1; write wen=1100 addr 0x2 → err=0.
